// File: rtl/bias_rd_sequencer.sv
// bias_rd_sequencer: walks each conv layer's bias ROM groups and hands them out over valid/ready.
// Define BIAS_SEQ_STATUS_EN to expose group_idx and a sticky abort_flag.
module bias_rd_sequencer #(
  parameter int RD_ADDR_DEPTH = 9,
  parameter int L0_BASE = 0,
  parameter int L0_CNT = 4,
  parameter int L1_BASE = 4,
  parameter int L1_CNT = 8,
  parameter int L2_BASE = 12,
  parameter int L2_CNT = 16,
  parameter int L3_BASE = 28,
  parameter int L3_CNT = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic [2:0] current_state,
  input  logic bias_ready,
  output logic [RD_ADDR_DEPTH-1:0] addr_rd,
  output logic bias_out_valid,
  output logic state_rst
`ifdef BIAS_SEQ_STATUS_EN
  ,
  output logic [RD_ADDR_DEPTH:0] group_idx,
  output logic abort_flag
`endif
);
  localparam int CW = RD_ADDR_DEPTH + 1;
  localparam int TOP = 1 << RD_ADDR_DEPTH;
  typedef enum logic [1:0] {IDLE, FETCH, VALID, DONE} state_e;
  state_e state_q;
  logic [2:0] prev_q;
  logic [CW-1:0] cnt_q;
  logic is_layer, chg, xfer, last;
  logic [RD_ADDR_DEPTH-1:0] base;
  logic [CW-1:0] num;
  if (L0_BASE + L0_CNT > TOP || L1_BASE + L1_CNT > TOP ||
      L2_BASE + L2_CNT > TOP || L3_BASE + L3_CNT > TOP) begin : g_range_chk
    $error("bias_rd_sequencer: a layer's BASE+CNT-1 exceeds the ROM address range");
  end
  always_comb begin
    is_layer = current_state inside {[3'd1:3'd4]};
    chg = current_state != prev_q;
    xfer = bias_out_valid && bias_ready;
    base = current_state == 3'd1 ? RD_ADDR_DEPTH'(L0_BASE) :
           current_state == 3'd2 ? RD_ADDR_DEPTH'(L1_BASE) :
           current_state == 3'd3 ? RD_ADDR_DEPTH'(L2_BASE) : RD_ADDR_DEPTH'(L3_BASE);
    num = current_state == 3'd1 ? CW'(L0_CNT) :
          current_state == 3'd2 ? CW'(L1_CNT) :
          current_state == 3'd3 ? CW'(L2_CNT) : CW'(L3_CNT);
    last = cnt_q == num - CW'(1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      prev_q <= 3'd0;
      cnt_q <= '0;
      addr_rd <= '0;
      bias_out_valid <= 1'b0;
      state_rst <= 1'b0;
    end else begin
      prev_q <= current_state;
      bias_out_valid <= 1'b0;
      state_rst <= 1'b0;
      // a change to a layer code restarts from that layer's base, whatever state we are in
      if (chg && is_layer) begin
        addr_rd <= base;
        cnt_q <= '0;
        state_q <= num == '0 ? DONE : FETCH;
        state_rst <= num == '0;
      end else if (chg && state_q != IDLE) begin
        cnt_q <= '0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          FETCH: begin
            state_q <= VALID;
            bias_out_valid <= 1'b1;
          end
          VALID: begin
            if (!xfer) begin
              bias_out_valid <= 1'b1;
            end else if (last) begin
              state_q <= DONE;
              state_rst <= 1'b1;
            end else begin
              addr_rd <= addr_rd + RD_ADDR_DEPTH'(1);
              cnt_q <= cnt_q + CW'(1);
              state_q <= FETCH;
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
`ifdef BIAS_SEQ_STATUS_EN
  logic abort_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) abort_q <= 1'b0;
    else if (chg && state_q != IDLE) abort_q <= 1'b1;
  end
  assign group_idx = cnt_q;
  assign abort_flag = abort_q;
`endif
endmodule

// File: doc/bias_rd_sequencer.md
Name: bias_rd_sequencer

Overview:
- Read-address sequencer and valid/ready front end for the bias ROM path.
- Sits directly upstream of the bias memory top level. Drives its addr_rd and bias_out_valid inputs and returns a layer-done pulse (state_rst) to the top-level layer FSM.
- On entry to each conv-layer state, walks that layer's bias groups in the ROM one at a time. Each group is handed to the PE consumer with a valid/ready handshake.

Parameters:
- RD_ADDR_DEPTH, 9, width of the bias ROM read address.
- L0_BASE, 0, first ROM address of layer 0 (current_state 3'd1).
- L0_CNT, 4, bias groups in layer 0.
- L1_BASE, 4, first ROM address of layer 1 (current_state 3'd2).
- L1_CNT, 8, bias groups in layer 1.
- L2_BASE, 12, first ROM address of layer 2 (current_state 3'd3).
- L2_CNT, 16, bias groups in layer 2.
- L3_BASE, 28, first ROM address of layer 3 (current_state 3'd4).
- L3_CNT, 32, bias groups in layer 3.

Ports:
- clk  input  1  system clock, 100 MHz.
- rstn  input  1  asynchronous, active-low reset.
- current_state  input  3  top-level layer state: 1..4 are layers 0..3; 0 and 5..7 are non-layer codes.
- bias_ready  input  1  consumer accepts the current bias group.
- addr_rd  output  RD_ADDR_DEPTH  bias ROM read address (registered).
- bias_out_valid  output  1  ROM data for addr_rd is on the bias bus (registered).
- state_rst  output  1  one-cycle pulse: all groups of the current layer have been transferred.

Behaviour:
- Reset, asynchronous: addr_rd=0, bias_out_valid=0, state_rst=0, FSM=IDLE, group counter=0, prev_state=0.
- prev_state register holds the last sampled current_state. A "change" is current_state != prev_state, sampled at a rising edge.
- ROM read latency is 1 cycle: data for addr_rd is valid the cycle after addr_rd is registered.
- FSM states: IDLE, FETCH, VALID, DONE.
- IDLE:
  - On a change to a layer code, load addr_rd<=BASE and cnt<=0, then go to FETCH.
  - If that layer's CNT==0, go straight to DONE instead.
  - No change: stay in IDLE. A layer is never re-run without a state change.
- FETCH: one cycle, covers ROM latency; bias_out_valid=0. Next state is VALID.
- VALID: bias_out_valid=1. A transfer is bias_out_valid && bias_ready.
  - No transfer: addr_rd and bias_out_valid hold.
  - Transfer with cnt<CNT-1: addr_rd<=addr_rd+1, cnt+1, go to FETCH.
  - Transfer with cnt==CNT-1: go to DONE.
- DONE: state_rst=1 for exactly this cycle, bias_out_valid=0; next state is IDLE.
- Latency: change sampled at edge E gives addr_rd=BASE after E+1 and bias_out_valid=1 after E+2. Throughput is 1 group per 2 cycles with bias_ready held high.
- Abort: a change seen in FETCH, VALID or DONE drops bias_out_valid at the next edge.
  - The DONE pulse still completes if the FSM was already in DONE; otherwise no state_rst.
  - If the new code is a layer, behave as the IDLE entry for that layer in the same edge (FETCH with the new BASE). Otherwise go to IDLE.
- Non-layer codes never start a sequence.
- addr_rd wraps modulo 2^RD_ADDR_DEPTH; BASE+CNT-1 must not exceed 2^RD_ADDR_DEPTH-1 (parameter check in simulation).
- Group counter is RD_ADDR_DEPTH+1 bits wide.
- Reset asserted mid-layer returns all outputs to their reset values immediately.

Optional Feature:
- BIAS_SEQ_STATUS_EN.
- Defined, adds two outputs:
  - group_idx [RD_ADDR_DEPTH:0] = current cnt; reset 0.
  - abort_flag, a sticky 1 set by any abort; cleared only by rstn.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset: hold rstn=0 with random inputs -> addr_rd=0, bias_out_valid=0, state_rst=0 throughout.
- Layer 0, bias_ready=1: current_state 0->1 at edge E -> addr_rd 0,1,2,3. bias_out_valid high at E+2, E+4, E+6, E+8. state_rst high exactly at E+9, then IDLE with no re-trigger.
- Backpressure: layer 1, bias_ready=0 for 5 cycles in VALID at group 2 -> addr_rd=6 and bias_out_valid=1 held all 5 cycles. Advance to 7 only after ready.
- Abort: layer 3, current_state 4->2 while cnt=5 -> bias_out_valid=0 next edge, no state_rst. Layer 1 restarts at addr_rd=4. With BIAS_SEQ_STATUS_EN, abort_flag=1 and group_idx=0.
- Non-layer codes: current_state 0->5->0 -> no FETCH, outputs stay at reset values.
- Zero-count layer: L2_CNT=0, current_state -> 3 -> bias_out_valid never asserts; state_rst pulses at E+1.
